// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: glyph table, bus bit positions,
// capture FSM states and small helpers.
package seven_seg_pkg;

    localparam int SEL_IDX     = 7;
    localparam int SEG_MSB_IDX = 6;
    localparam int SEG_LSB_IDX = 0;

    localparam logic SEL_LSB = 1'b1;

    // Active-high glyphs, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic {
        WAIT_FIRST  = 1'b0,
        WAIT_SECOND = 1'b1
    } cap_state_t;

    function automatic logic is_bcd(input logic [3:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/seven_seg_unhex.sv
// Inverse of the glyph table: active-high segment pattern to nibble.
// Anything that is not one of the sixteen hex glyphs drops hit.
import seven_seg_pkg::*;

module seven_seg_unhex (
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       hit
);

    always_comb begin
        nibble = 4'h0;
        hit    = 1'b1;
        case (pattern)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed two-digit seven-segment bus, debounces each
// digit and reassembles the displayed byte.
import seven_seg_pkg::*;

module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       bcd_ok,
    output logic       decode_err,
    output logic       stale
);

    localparam int RW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]    s_q;
    logic [7:0]    s_prev;
    logic [RW-1:0] run;
    logic [RW-1:0] run_next;
    logic          accept;
    logic [TW-1:0] tcnt;
    cap_state_t    state;
    logic [3:0]    held_nib;
    logic          held_sel;
    logic [6:0]    pattern;
    logic [3:0]    nib;
    logic          hit;
    logic          sel;
    logic [7:0]    frame;

    // Accept fires only on the transition into saturation
    always_comb begin
        run_next = run;
        if (s_q != s_prev)
            run_next = RW'(1);
        else if (run != RUN_MAX)
            run_next = run + RW'(1);
        accept = (run_next == RUN_MAX) && (run != RUN_MAX);
    end

    assign pattern = ~s_q[SEG_MSB_IDX:SEG_LSB_IDX];
    assign sel     = s_q[SEL_IDX];

    seven_seg_unhex u_unhex (
        .pattern (pattern),
        .nibble  (nib),
        .hit     (hit)
    );

    always_comb begin
        if (sel == SEL_LSB)
            frame = {held_nib, nib};
        else
            frame = {nib, held_nib};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            s_prev      <= '0;
            run         <= '0;
            tcnt        <= '0;
            state       <= WAIT_FIRST;
            held_nib    <= '0;
            held_sel    <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            bcd_ok      <= 1'b0;
            decode_err  <= 1'b0;
            stale       <= 1'b0;
        end else begin
            s_q         <= seg_in;
            s_prev      <= s_q;
            run         <= run_next;
            value_valid <= 1'b0;
            decode_err  <= 1'b0;
            if (accept) begin
                // Accept beats a coincident timeout
                tcnt  <= '0;
                stale <= 1'b0;
                if (!hit) begin
                    decode_err <= 1'b1;
                    state      <= WAIT_FIRST;
                end else begin
                    unique case (state)
                        WAIT_FIRST: begin
                            held_nib <= nib;
                            held_sel <= sel;
                            state    <= WAIT_SECOND;
                        end
                        WAIT_SECOND: begin
                            if (sel != held_sel) begin
                                value       <= frame;
                                bcd_ok      <= is_bcd(frame[7:4])
                                             && is_bcd(frame[3:0]);
                                value_valid <= 1'b1;
                                state       <= WAIT_FIRST;
                            end else begin
                                held_nib <= nib;
                            end
                        end
                    endcase
                end
            end else if (tcnt != T_MAX) begin
                tcnt <= tcnt + TW'(1);
                if (tcnt == T_LAST) begin
                    stale <= 1'b1;
                    state <= WAIT_FIRST;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scenarios plus
// randomized dwells checked against a window-based reference model.
module tb_seven_seg_capture;

    localparam int S = 4;
    localparam int T = 4096;

    localparam logic [6:0] GL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg_in = 8'h00;
    logic [7:0] value;
    logic       value_valid;
    logic       bcd_ok;
    logic       decode_err;
    logic       stale;

    int checks = 0;
    int errors = 0;

    seven_seg_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .value       (value),
        .value_valid (value_valid),
        .bcd_ok      (bcd_ok),
        .decode_err  (decode_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic sel, input int d);
        return {sel, ~GL[d]};
    endfunction

    // Reference model: a pattern is accepted one edge after exactly S
    // equal consecutive samples preceded by a different one.
    int         q [0:S];
    int         since;
    bit         held;
    int         held_sel;
    int         held_nib;
    logic [7:0] m_value;
    bit         m_bcd, m_vv, m_err, m_stale;

    function automatic int lookup(input int seg);
        for (int i = 0; i < 16; i++)
            if (int'(GL[i]) == seg) return i;
        return -1;
    endfunction

    always @(posedge clk) begin
        bit acc;
        int d, sl;
        m_vv  = 0;
        m_err = 0;
        if (rst) begin
            q[0] = 0;
            for (int i = 1; i <= S; i++) q[i] = -1;
            since = 0; m_stale = 0; held = 0;
            m_value = 0; m_bcd = 0;
        end else begin
            acc = (q[S] != q[0]);
            for (int i = 1; i < S; i++)
                if (q[i] != q[0]) acc = 0;
            if (acc) begin
                since = 0;
                m_stale = 0;
                sl = (q[0] >> 7) & 1;
                d  = lookup((~q[0]) & 'h7F);
                if (d < 0) begin
                    m_err = 1;
                    held = 0;
                end else if (!held) begin
                    held = 1; held_sel = sl; held_nib = d;
                end else if (sl != held_sel) begin
                    m_value = (sl == 1) ? 8'(held_nib * 16 + d)
                                        : 8'(d * 16 + held_nib);
                    m_bcd = (held_nib <= 9) && (d <= 9);
                    m_vv = 1;
                    held = 0;
                end else begin
                    held_nib = d;
                end
            end else if (since < T) begin
                since++;
                if (since == T) begin
                    m_stale = 1;
                    held = 0;
                end
            end
            for (int i = S; i >= 1; i--) q[i] = q[i-1];
            q[0] = int'(seg_in);
        end
    end

    int mon_bad = 0;
    int n_vv = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (value_valid !== m_vv || decode_err !== m_err
            || stale !== m_stale || value !== m_value
            || bcd_ok !== m_bcd)
            mon_bad++;
        if (value_valid === 1'b1) n_vv++;
        if (decode_err === 1'b1) n_err++;
    end

    task automatic hold(input logic [7:0] v, input int n);
        seg_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        seg_in = 8'h00;
        repeat (3) @(negedge clk);
        checks += 5;
        if (value !== 8'h00) begin
            errors++; $display("FAIL reset_value got %h want 00", value);
        end
        if (value_valid !== 1'b0) begin
            errors++; $display("FAIL reset_vv got %b want 0", value_valid);
        end
        if (bcd_ok !== 1'b0) begin
            errors++; $display("FAIL reset_bcd got %b want 0", bcd_ok);
        end
        if (decode_err !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b want 0", decode_err);
        end
        if (stale !== 1'b0) begin
            errors++; $display("FAIL reset_stale got %b want 0", stale);
        end
        rst = 1'b0;
        seg_in = mk(1'b0, 4);
    endtask

    task automatic test_basic;
        int first, cnt;
        first = 0;
        cnt = 0;
        hold(mk(1'b0, 4), 1024);
        seg_in = mk(1'b1, 2);
        for (int e = 1; e <= 1024; e++) begin
            @(posedge clk);
            #1;
            if (value_valid === 1'b1) begin
                if (first == 0) first = e;
                cnt++;
            end
        end
        @(negedge clk);
        checks += 4;
        if (first != 5) begin
            errors++; $display("FAIL basic_latency got %0d want 5", first);
        end
        if (cnt != 1) begin
            errors++; $display("FAIL basic_pulses got %0d want 1", cnt);
        end
        if (value !== 8'h42) begin
            errors++; $display("FAIL basic_value got %h want 42", value);
        end
        if (bcd_ok !== 1'b1) begin
            errors++; $display("FAIL basic_bcd got %b want 1", bcd_ok);
        end
    endtask

    task automatic test_glitch;
        int vv0, er0;
        vv0 = n_vv;
        er0 = n_err;
        hold(mk(1'b0, 4), 10);
        hold(8'h55, 2);
        hold(mk(1'b1, 7), 3);
        checks += 2;
        if (n_vv != vv0) begin
            errors++; $display("FAIL glitch_vv got %0d want 0", n_vv - vv0);
        end
        if (n_err != er0) begin
            errors++; $display("FAIL glitch_err got %0d want 0", n_err - er0);
        end
        hold(mk(1'b1, 7), 10);
        checks += 2;
        if (value !== 8'h47) begin
            errors++; $display("FAIL glitch_value got %h want 47", value);
        end
        if (n_vv - vv0 != 1) begin
            errors++; $display("FAIL glitch_frame got %0d want 1", n_vv - vv0);
        end
    endtask

    task automatic test_dash;
        int er0;
        er0 = n_err;
        hold({1'b1, ~7'h40}, 10);
        checks += 2;
        if (n_err - er0 != 1) begin
            errors++; $display("FAIL dash_err got %0d want 1", n_err - er0);
        end
        if (value !== 8'h47) begin
            errors++; $display("FAIL dash_hold got %h want 47", value);
        end
        hold(mk(1'b0, 5), 10);
        hold(mk(1'b1, 6), 10);
        checks++;
        if (value !== 8'h56) begin
            errors++; $display("FAIL dash_after got %h want 56", value);
        end
    endtask

    task automatic test_stale;
        int vv0;
        hold(mk(1'b0, 1), T + S + 4);
        checks++;
        if (stale !== 1'b1) begin
            errors++; $display("FAIL stale_set got %b want 1", stale);
        end
        vv0 = n_vv;
        hold(mk(1'b1, 3), 10);
        checks += 2;
        if (n_vv != vv0) begin
            errors++; $display("FAIL stale_lone got %0d want 0", n_vv - vv0);
        end
        if (stale !== 1'b0) begin
            errors++; $display("FAIL stale_clr got %b want 0", stale);
        end
        hold(mk(1'b0, 8), 10);
        hold(mk(1'b1, 3), 10);
        checks += 2;
        if (n_vv - vv0 < 1) begin
            errors++; $display("FAIL stale_pair got %0d want >=1", n_vv - vv0);
        end
        if (value !== 8'h83) begin
            errors++; $display("FAIL stale_value got %h want 83", value);
        end
    endtask

    task automatic test_hex;
        hold(mk(1'b0, 0), 2);
        hold({1'b1, 7'h7F}, 10);
        hold(mk(1'b1, 15), 10);
        hold(mk(1'b0, 10), 10);
        checks += 2;
        if (value !== 8'hAF) begin
            errors++; $display("FAIL hex_value got %h want af", value);
        end
        if (bcd_ok !== 1'b0) begin
            errors++; $display("FAIL hex_bcd got %b want 0", bcd_ok);
        end
    endtask

    task automatic test_mid_reset;
        int vv0;
        hold(mk(1'b1, 0), 10);
        hold(mk(1'b0, 9), 10);
        rst = 1'b1;
        seg_in = mk(1'b1, 3);
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (value !== 8'h00 || bcd_ok !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_value got %h/%b want 00/0", value, bcd_ok);
        end
        if (value_valid !== 1'b0 || decode_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_pulse got %b%b want 00",
                     value_valid, decode_err);
        end
        if (stale !== 1'b0) begin
            errors++; $display("FAIL mid_rst_stale got %b want 0", stale);
        end
        vv0 = n_vv;
        hold(mk(1'b1, 3), 30);
        checks++;
        if (n_vv != vv0) begin
            errors++; $display("FAIL mid_rst_lone got %0d want 0", n_vv - vv0);
        end
        hold(mk(1'b0, 9), 10);
        checks++;
        if (value !== 8'h93) begin
            errors++; $display("FAIL mid_rst_value2 got %h want 93", value);
        end
    endtask

    task automatic test_random;
        logic [7:0] v;
        int r;
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 80)
                v = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            else
                v = 8'($urandom);
            hold(v, int'($urandom_range(1, 8)));
            checks++;
            if (value !== m_value || bcd_ok !== m_bcd || stale !== m_stale) begin
                errors++;
                $display("FAIL random_%0d got %h/%b/%b want %h/%b/%b", k,
                         value, bcd_ok, stale, m_value, m_bcd, m_stale);
            end
        end
    endtask

    task automatic test_monitor;
        checks++;
        if (mon_bad != 0) begin
            errors++;
            $display("FAIL cycle_model got %0d bad cycles want 0", mon_bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_dash();
        test_stale();
        test_hex();
        test_mid_reset();
        test_random();
        test_monitor();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
